apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
- APB requester (initiator) that drives the same APB signal set our completer answers.
- Converts a simple valid/ready command port into APB SETUP/ACCESS transfers, one transfer at a time.
- Returns read data and error status on a valid/ready response port.
- Used as the RTL master in front of the APB completer, and as the bus driver in subsystem benches.

Parameters:
ADDR_W, 32, width of paddr and cmd_addr
DATA_W, 32, width of pwdata/prdata and the command/response data
TIMEOUT, 16, maximum ACCESS cycles allowed before abort; 0 disables the timeout

Ports:
pclk  in  1  bus clock; all logic on rising edge
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pselx  out  1  APB select
penable  out  1  APB enable
prdata  in  DATA_W  APB read data
pready  in  1  completer ready
pslverr  in  1  completer error

Behaviour:
- Reset (presetn low, asynchronous):
  - state=IDLE; pselx, penable, paddr, pwrite, pwdata all 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; wait counter 0.
  - cmd_ready held 0 while presetn is low.
- States: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On accept: capture cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata, set pselx=1, penable=0, go to SETUP.
  - cmd_ready=0 in every other state.
- SETUP: lasts exactly one cycle. Set penable=1, clear the wait counter, go to ACCESS.
- ACCESS:
  - pselx=1, penable=1; paddr/pwrite/pwdata stable.
  - If pready=1: capture rsp_rdata=prdata (reads) or 0 (writes), rsp_err=pslverr, rsp_timeout=0. Clear pselx and penable, go to RESP.
  - Else if TIMEOUT!=0 and the wait counter equals TIMEOUT-1: rsp_rdata=0, rsp_err=1, rsp_timeout=1. Clear pselx and penable, go to RESP.
  - Else: increment the wait counter (saturating width $clog2(TIMEOUT+1)).
  - pslverr and prdata are ignored whenever pready=0.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err/rsp_timeout held stable until accept.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - A new command is accepted no earlier than the cycle after the response handshake.
- Latency: accept at edge N. SETUP during cycle N+1, ACCESS from N+2. With zero wait states, rsp_valid=1 from N+3. Each wait state adds one cycle.
- Address and data outputs keep their last values in IDLE and RESP. Only pselx/penable return to 0.
- pselx=0 implies penable=0 at all times. penable never rises without a preceding SETUP cycle.
- Reset asserted in SETUP, ACCESS or RESP aborts immediately to the reset values. No response is produced for the aborted transfer.
- cmd_valid held high during RESP has no effect until IDLE is re-entered.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_req_state_e {IDLE, SETUP, ACCESS, RESP};
  - default ADDR_W/DATA_W constants;
  - response struct {rdata, err, timeout}.
- No sub-module; timeout counter and FSM live in apb_requester.

Test Plan:
- Zero-wait write: cmd write addr=0x10 data=0xA5A5_0001, pready tied 1 -> pselx high 2 cycles, penable high 1 cycle; rsp_valid at accept+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x14, pready rises on the 4th ACCESS cycle with prdata=0x1234_5678 -> rsp_rdata=0x1234_5678; paddr stable through all ACCESS cycles; rsp_valid at accept+6.
- Slave error: read addr=0xFFC, pready=1 with pslverr=1 -> rsp_err=1, rsp_timeout=0; pslverr=1 while pready=0 on an earlier cycle is ignored.
- Timeout: TIMEOUT=4, pready held 0 -> penable drops after exactly 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Backpressure and back-to-back: rsp_ready=0 for 5 cycles with cmd_valid held high -> response fields stable, cmd_ready=0, no new SETUP; second command accepted the cycle after rsp_ready.
- Reset mid-ACCESS: assert presetn=0 during a wait state -> pselx/penable/rsp_valid go 0 asynchronously; after release, cmd_ready=1 and the next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types and defaults used by the APB requester and its benches.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_req_state_e;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_requester.sv
// APB requester: turns one valid/ready command into one APB SETUP/ACCESS
// transfer and returns its read data and error status on a valid/ready response.
module apb_requester
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   output logic              pselx,
   output logic              penable,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   // A zero TIMEOUT still needs a legal one-bit counter.
   localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   apb_req_state_e    state, state_d;
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
   logic [ADDR_W-1:0] paddr_d;
   logic              pwrite_d;
   logic [DATA_W-1:0] pwdata_d;
   logic              pselx_d;
   logic              penable_d;
   logic              rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_d;
   logic              rsp_err_d;
   logic              rsp_timeout_d;

   assign cmd_ready = (state == IDLE) && presetn;

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d       = state;
      wait_cnt_d    = wait_cnt;
      paddr_d       = paddr;
      pwrite_d      = pwrite;
      pwdata_d      = pwdata;
      pselx_d       = pselx;
      penable_d     = penable;
      rsp_valid_d   = rsp_valid;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;

      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d   = cmd_addr;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_wdata;
               pselx_d   = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end

         SETUP: begin
            penable_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ACCESS;
         end

         ACCESS: begin
            if (pready) begin
               rsp_rdata_d   = pwrite ? '0 : prdata;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               pselx_d       = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               pselx_d       = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end else if (wait_cnt != CNT_MAX) begin
               wait_cnt_d = wait_cnt + CNT_W'(1);
            end
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         pselx       <= 1'b0;
         penable     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking updates make every register see the values from
         // before this edge, regardless of statement order.
         state       <= state_d;
         wait_cnt    <= wait_cnt_d;
         paddr       <= paddr_d;
         pwrite      <= pwrite_d;
         pwdata      <= pwdata_d;
         pselx       <= pselx_d;
         penable     <= penable_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
      end
   end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed and random transfers against
// a transfer-level reference model, plus a reset-during-ACCESS sequence.
module tb_apb_requester;
   import apb_pkg::*;

   localparam int TO = 4;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, pselx, penable, pready, pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   // Completer behaviour for the transfer in flight.
   int          cur_waits = 0;
   logic [31:0] cur_prdata = '0;
   logic        cur_pslverr = 1'b0;
   logic        cur_wait_err = 1'b0;
   int          acc_idx = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      logic        wait_err;
      int          bp;
      apb_rsp_t    exp;
      int          exp_lat;
   } vec_t;

   vec_t vecs[19];

   apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pselx(pselx),
      .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   // Completer: answers after cur_waits wait states; junk on prdata/pslverr otherwise.
   always @(negedge pclk) begin
      if (pselx && penable) begin
         if (acc_idx >= cur_waits) begin
            pready  = 1'b1;
            prdata  = cur_prdata;
            pslverr = cur_pslverr;
         end else begin
            pready  = 1'b0;
            prdata  = $urandom;
            pslverr = cur_wait_err;
         end
         acc_idx++;
      end else begin
         acc_idx = 0;
         pready  = 1'($urandom_range(0, 1));
         prdata  = $urandom;
         pslverr = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference model: outcome of one transfer from its wait-state count alone.
   function automatic apb_rsp_t model_rsp(input logic wr, input int waits,
                                          input logic [31:0] rd, input logic slverr);
      apb_rsp_t r;
      if (TO != 0 && waits >= TO) begin
         r.rdata = '0; r.err = 1'b1; r.timeout = 1'b1;
      end else begin
         r.rdata = wr ? 32'h0 : rd; r.err = slverr; r.timeout = 1'b0;
      end
      return r;
   endfunction

   function automatic int model_lat(input int waits);
      return (waits >= TO) ? 2 + TO : 3 + waits;
   endfunction

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int waits, input logic [31:0] rd, input logic slverr,
                               input logic wait_err, input int bp, input logic [31:0] e_rdata,
                               input logic e_err, input logic e_to, input int e_lat);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.prdata = rd;
      v.slverr = slverr; v.wait_err = wait_err; v.bp = bp;
      v.exp.rdata = e_rdata; v.exp.err = e_err; v.exp.timeout = e_to; v.exp_lat = e_lat;
      return v;
   endfunction

   // Called on a falling edge with the requester idle; returns on a falling edge.
   task automatic run_vec(input vec_t v, input string name);
      int   n, acc, sel;
      logic done;
      int   exp_acc;
      cur_waits = v.waits; cur_prdata = v.prdata;
      cur_pslverr = v.slverr; cur_wait_err = v.wait_err;
      cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
      check({name, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
      @(posedge pclk);
      @(negedge pclk);
      cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      n = 1; acc = 0; sel = 0; done = 1'b0;
      while (!done && n < 40) begin
         check({name, ".pen_wo_sel"}, 64'(penable & ~pselx), 64'd0);
         if (pselx) sel++;
         if (pselx && penable) begin
            acc++;
            check({name, ".paddr"}, 64'(paddr), 64'(v.addr));
            check({name, ".pwrite"}, 64'(pwrite), 64'(v.wr));
            check({name, ".pwdata"}, 64'(pwdata), 64'(v.wdata));
         end
         if (rsp_valid) done = 1'b1;
         else begin
            @(negedge pclk);
            n++;
         end
      end
      exp_acc = (v.waits >= TO) ? TO : v.waits + 1;
      check({name, ".rsp_seen"}, 64'(done), 64'd1);
      check({name, ".latency"}, 64'(n), 64'(v.exp_lat));
      check({name, ".access_cycles"}, 64'(acc), 64'(exp_acc));
      check({name, ".psel_cycles"}, 64'(sel), 64'(exp_acc + 1));
      check({name, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp.rdata));
      check({name, ".rsp_err"}, 64'(rsp_err), 64'(v.exp.err));
      check({name, ".rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp.timeout));
      for (int i = 0; i < v.bp; i++) begin
         cmd_valid = 1'b1; cmd_addr = $urandom;
         @(negedge pclk);
         check({name, ".bp_valid"}, 64'(rsp_valid), 64'd1);
         check({name, ".bp_rdata"}, 64'(rsp_rdata), 64'(v.exp.rdata));
         check({name, ".bp_err"}, 64'({rsp_err, rsp_timeout}), 64'({v.exp.err, v.exp.timeout}));
         check({name, ".bp_cmd_ready"}, 64'(cmd_ready), 64'd0);
         check({name, ".bp_pselx"}, 64'(pselx), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check({name, ".rsp_drop"}, 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; rsp_ready = 1'b0;

      // Directed vectors with hand-derived expectations (TIMEOUT = 4).
      vecs[0] = mk(1, 32'h10,  32'hA5A5_0001, 0,  32'hDEAD_BEEF, 0, 0, 0, 32'h0,         0, 0, 3);
      vecs[1] = mk(0, 32'h14,  32'h0,         3,  32'h1234_5678, 0, 0, 0, 32'h1234_5678, 0, 0, 6);
      vecs[2] = mk(0, 32'hFFC, 32'h0,         2,  32'hCAFE_0000, 1, 1, 0, 32'hCAFE_0000, 1, 0, 5);
      vecs[3] = mk(0, 32'h20,  32'h0,         1,  32'h0BAD_F00D, 0, 1, 0, 32'h0BAD_F00D, 0, 0, 4);
      vecs[4] = mk(0, 32'h30,  32'h0,         99, 32'h7777_7777, 0, 0, 0, 32'h0,         1, 1, 6);
      vecs[5] = mk(1, 32'h34,  32'h5555_AAAA, 3,  32'h1111_1111, 0, 0, 0, 32'h0,         0, 0, 6);
      vecs[6] = mk(0, 32'h40,  32'h0,         0,  32'h8765_4321, 0, 0, 5, 32'h8765_4321, 0, 0, 3);
      // Random vectors; expectations from the transfer-level model.
      for (int i = 7; i < 19; i++) begin
         vecs[i].wr       = 1'($urandom_range(0, 1));
         vecs[i].addr     = $urandom & 32'hFFFF_FFFC;
         vecs[i].wdata    = $urandom;
         vecs[i].waits    = $urandom_range(0, 6);
         vecs[i].prdata   = $urandom;
         vecs[i].slverr   = 1'($urandom_range(0, 1));
         vecs[i].wait_err = 1'($urandom_range(0, 1));
         vecs[i].bp       = $urandom_range(0, 3);
         vecs[i].exp      = model_rsp(vecs[i].wr, vecs[i].waits, vecs[i].prdata, vecs[i].slverr);
         vecs[i].exp_lat  = model_lat(vecs[i].waits);
      end

      #12;
      check("reset.cmd_ready", 64'(cmd_ready), 64'd0);
      check("reset.apb", 64'({pselx, penable, pwrite}), 64'd0);
      check("reset.paddr", 64'(paddr), 64'd0);
      check("reset.pwdata", 64'(pwdata), 64'd0);
      check("reset.rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
      check("reset.rsp_rdata", 64'(rsp_rdata), 64'd0);
      @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);

      for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset asserted during a wait state aborts the transfer asynchronously.
      cur_waits = 99; cur_wait_err = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h88; cmd_wdata = 32'hFEED_0001;
      @(posedge pclk);
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      check("rst_mid.in_access", 64'({pselx, penable}), 64'b11);
      #2 presetn = 1'b0;
      #1;
      check("rst_mid.apb", 64'({pselx, penable, pwrite}), 64'd0);
      check("rst_mid.paddr", 64'(paddr), 64'd0);
      check("rst_mid.rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_mid.cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge pclk);
      presetn = 1'b1;
      #1;
      check("rst_mid.ready_after", 64'(cmd_ready), 64'd1);
      @(negedge pclk);
      check("rst_mid.no_rsp", 64'(rsp_valid), 64'd0);
      run_vec(mk(0, 32'h8C, 32'h0, 1, 32'h4242_4242, 0, 0, 0, 32'h4242_4242, 0, 0, 4), "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
